frame_pixel_streamer: RTL
=========================

Name: frame_pixel_streamer

Overview:
Raster-order pixel source for the streaming convolution filters. On a start pulse it reads one WIDTH x HEIGHT frame from a synchronous-read frame memory. It emits every pixel once, with its linear address, on a valid/ready stream, plus start-of-line and end-of-frame markers. It is the producing end of the filters' pixel+address input interface.

Parameters:
WIDTH, 256, pixels per line
HEIGHT, 256, lines per frame
PIX_W, 8, pixel width in bits
ADDR_W, 16, address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
BUF_DEPTH, 2, output skid buffer entries; fixed at 2 for 1-cycle memory latency

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to stream a frame; ignored unless idle
busy  out  1  high from accepted start until done pulse inclusive
done  out  1  one-cycle pulse after last pixel handshake
mem_rd_en  out  1  frame memory read strobe
mem_rd_addr  out  ADDR_W  frame memory read address
mem_rd_data  in  PIX_W  read data, valid exactly 1 cycle after mem_rd_en
out_valid  out  1  stream beat valid
out_ready  in  1  downstream accept
out_pixel  out  PIX_W  pixel value
out_addr  out  ADDR_W  linear address y*WIDTH+x of out_pixel
out_sol  out  1  beat is x==0
out_eof  out  1  beat is last pixel of frame (x==WIDTH-1, y==HEIGHT-1)

Behaviour:
- Reset values: busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_pixel=0, out_addr=0, out_sol=0, out_eof=0. Buffer empty, in-flight cleared, state IDLE.
- Reset mid-frame aborts immediately. No done pulse. Next frame needs a new start.
- States:
  - IDLE: start=1 -> FETCH; clear read counter rd_idx=0 and beat counter.
  - FETCH: issue reads until rd_idx reaches WIDTH*HEIGHT, then go to DRAIN.
  - DRAIN: wait until the buffer is empty, no read is in flight, and the final beat has been handshaken; then go to DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start is ignored outside IDLE. A start in the same cycle as the DONE pulse is ignored.
- Read issue rule, evaluated combinationally each cycle in FETCH: mem_rd_en=1 iff rd_idx < WIDTH*HEIGHT and (occupancy + inflight - pop) < BUF_DEPTH.
  - pop = out_valid & out_ready.
  - mem_rd_addr = rd_idx.
  - rd_idx increments on each issued read.
- Data returning 1 cycle after issue is written into the FIFO. Each FIFO entry carries pixel, address, sol and eof. Address, sol and eof are computed from the issue-time rd_idx, delayed one cycle with the read.
- Overflow is impossible by the credit rule. A write into a full buffer is a design error; verification asserts it never happens.
- Output: out_valid = buffer non-empty. The head entry drives out_pixel, out_addr, out_sol and out_eof, held stable while out_valid & !out_ready.
- Simultaneous push and pop leaves occupancy unchanged.
- Latency, with start high in cycle 0:
  - FETCH from cycle 1.
  - mem_rd_en=1 with address 0 in cycle 1.
  - Data arrives in cycle 2 and is written into the buffer at the end of cycle 2.
  - out_valid=1 for address 0 in cycle 3.
- Throughput: with out_ready held at 1, one beat per clock with no bubbles. Last beat in cycle WIDTH*HEIGHT+2. DRAIN is entered in cycle WIDTH*HEIGHT+1, DONE is reached in cycle WIDTH*HEIGHT+3, and done=1 in that cycle.
- Backpressure: out_ready=0 stalls issue within 1 cycle. At most BUF_DEPTH pixels are buffered, and none are lost or duplicated.
- Addresses never wrap within a frame. The x/y counters wrap only at the end of the frame, and x/y are derived from a counter pair, not a divide.
- out_valid, out_pixel, out_addr, out_sol and out_eof go to 0 when the buffer is empty; they do not hold the last value.

Decomposition:
- Shared package for the convolution codebase holds:
  - the PIX_W and ADDR_W defaults;
  - the frame-size constants WIDTH and HEIGHT;
  - the state encoding (IDLE, FETCH, DRAIN, DONE) as a typedef;
  - the stream beat struct (pixel, addr, sol, eof).
- One sub-module, stream_skid_fifo: a BUF_DEPTH-entry FIFO of beat structs exposing occupancy, push, pop and head. It is reusable on the filter output side.

Test Plan:
- Set WIDTH=4, HEIGHT=3, memory word at address a preloaded with a+0x10, out_ready=1, start in cycle 0:
  - out_valid is first high in cycle 3 with pixel 0x10, addr 0, sol=1.
  - 12 consecutive beats follow; the last has pixel 0x1B, addr 11, eof=1.
  - done pulses in cycle 15.
  - busy is high in cycles 1-15.
- Same setup with out_ready toggling 1,0,0,1 repeating:
  - exactly 12 beats are accepted, in order 0..11;
  - held beats are stable while out_ready=0;
  - occupancy never exceeds 2;
  - out_sol is high at addrs 0, 4, 8.
- Pulse start while busy at beat 5 -> ignored: beat count stays 12 and there is a single done.
- Assert rst at beat 6 of 12 -> all outputs 0 in the same cycle, no done pulse. A new start then restarts at addr 0 with 12 full beats.
- Run back-to-back frames by pulsing start the cycle after done -> the second frame matches the first beat for beat, and out_addr restarts at 0.
- Hold out_ready=0 from before the first beat -> mem_rd_en issues exactly 2 reads, then stays low until out_ready rises.

Source files
------------

// File: rtl/frame_pixel_streamer_pkg.sv
// frame_pixel_streamer_pkg: shared constants, FSM states and stream beat type for the convolution pipeline
package frame_pixel_streamer_pkg;
  localparam int PIX_W_DEF = 8;
  localparam int ADDR_W_DEF = 16;
  localparam int FRAME_WIDTH = 256;
  localparam int FRAME_HEIGHT = 256;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;
  typedef struct packed {
    logic [PIX_W_DEF-1:0] pixel;
    logic [ADDR_W_DEF-1:0] addr;
    logic sol;
    logic eof;
  } beat_t;
endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: small circular buffer of stream beats; head reads as zero while empty
module stream_skid_fifo
  import frame_pixel_streamer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  beat_t din,
  input  logic pop,
  output beat_t head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  beat_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign head = count != '0 ? mem[rp] : '0;
  // storage write; the producer's credit scheme must never push into a full buffer
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
    if (push && !pop) assert (count != CW'(DEPTH));
  end
  // pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer: raster-order frame reader emitting pixel+address beats on a valid/ready stream
module frame_pixel_streamer
  import frame_pixel_streamer_pkg::*;
#(
  parameter int WIDTH = FRAME_WIDTH,
  parameter int HEIGHT = FRAME_HEIGHT,
  parameter int PIX_W = PIX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [PIX_W-1:0] mem_rd_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic [ADDR_W-1:0] out_addr,
  output logic out_sol,
  output logic out_eof
);
  localparam int N = WIDTH * HEIGHT;
  localparam int OW = $clog2(BUF_DEPTH + 1);
  state_t state;
  logic [ADDR_W:0] rd_idx;
  logic [ADDR_W-1:0] x, y, pend_addr;
  logic inflight, pend_sol, pend_eof, rd_go, pop, last_col, last_row;
  logic [OW-1:0] occ;
  beat_t head, din;
  stream_skid_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(inflight),
    .din(din),
    .pop(pop),
    .head(head),
    .count(occ)
  );
  // read credit: never let buffered plus in-flight beats exceed the buffer once this cycle's pop is counted
  always_comb begin
    out_valid = occ != '0;
    pop = out_valid && out_ready;
    last_col = x == ADDR_W'(WIDTH - 1);
    last_row = y == ADDR_W'(HEIGHT - 1);
    rd_go = state == S_FETCH && rd_idx < (ADDR_W+1)'(N) &&
            (32'(occ) + 32'(inflight) - 32'(pop)) < 32'(BUF_DEPTH);
    mem_rd_en = rd_go;
    mem_rd_addr = rd_go ? rd_idx[ADDR_W-1:0] : '0;
    din = '{pixel: mem_rd_data, addr: pend_addr, sol: pend_sol, eof: pend_eof};
    out_pixel = head.pixel;
    out_addr = head.addr;
    out_sol = head.sol;
    out_eof = head.eof;
  end
  // frame sequencing with raster x/y counters advanced per issued read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      rd_idx <= '0;
      x <= '0;
      y <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_FETCH;
          busy <= 1'b1;
          rd_idx <= '0;
          x <= '0;
          y <= '0;
        end
        S_FETCH: if (rd_go) begin
          rd_idx <= rd_idx + 1'b1;
          x <= last_col ? '0 : x + 1'b1;
          y <= last_col ? (last_row ? '0 : y + 1'b1) : y;
          if (rd_idx == (ADDR_W+1)'(N - 1)) state <= S_DRAIN;
        end
        S_DRAIN: if (!inflight && occ == OW'(pop)) begin
          state <= S_DONE;
          done <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  // beat metadata travels alongside the one-cycle memory read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      inflight <= 1'b0;
      pend_addr <= '0;
      pend_sol <= 1'b0;
      pend_eof <= 1'b0;
    end else begin
      inflight <= rd_go;
      if (rd_go) begin
        pend_addr <= rd_idx[ADDR_W-1:0];
        pend_sol <= x == '0;
        pend_eof <= last_col && last_row;
      end
    end
endmodule
